// File: rtl/ssm_scan_if.sv
// Display-driver bus: shadow load inputs, display controls and the registered pin outputs.
interface ssm_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      blank_lz;
  logic                      enable;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     an;

  modport master (
    output load, value, dp_in, blank_lz, enable,
    input  seg, dp, an
  );

  modport slave (
    input  load, value, dp_in, blank_lz, enable,
    output seg, dp, an
  );
endinterface

// File: rtl/ssm_scan.sv
// Multiplexed multi-digit seven-segment driver: shadowed hex value, time-sliced
// digit scan with anti-ghost blanking, hex decode, decimal points and leading-zero blanking.
module ssm_scan #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  ssm_scan_if.slave    bus
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         sh_val;
  logic [NUM_DIGITS-1:0] sh_dp;

  logic [NUM_DIGITS-1:0] lz_c;
  logic [3:0]            nib_c;
  logic                  lz_sel_c;
  logic                  dp_sel_c;
  logic [NUM_DIGITS-1:0] sel_c;
  logic [6:0]            lit_c;
  logic [6:0]            seg_nxt_c;
  logic                  dp_nxt_c;
  logic [NUM_DIGITS-1:0] an_nxt_c;

  // Active-high hex decode, segment a in bit 0.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    hex7 = 7'h00;
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

  // Per digit: this nibble and every higher one are zero.
  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_lz
      assign lz_c[g] = ~|sh_val[VW-1:4*g];
    end
  endgenerate

  // Select the current digit's data and form the next pin values.
  always_comb begin
    nib_c    = 4'h0;
    lz_sel_c = 1'b0;
    dp_sel_c = 1'b0;
    sel_c    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib_c    = sh_val[4*i +: 4];
        lz_sel_c = lz_c[i];
        dp_sel_c = sh_dp[i];
        sel_c[i] = bus.enable && (cnt != '0);
      end
    end
    lit_c     = (bus.blank_lz && (idx != '0) && lz_sel_c) ? 7'h00 : hex7(nib_c);
    seg_nxt_c = (SEG_ACTIVE_LOW != 0) ? ~lit_c : lit_c;
    dp_nxt_c  = (SEG_ACTIVE_LOW != 0) ? ~dp_sel_c : dp_sel_c;
    an_nxt_c  = (AN_ACTIVE_LOW != 0) ? ~sel_c : sel_c;
  end

  // Free-running slot counter and digit index; independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Shadow capture; re-captures every cycle load is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val <= '0;
      sh_dp  <= '0;
    end else if (bus.load) begin
      sh_val <= bus.value;
      sh_dp  <= bus.dp_in;
    end
  end

  // Registered pin outputs, one cycle behind the scan state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg <= SEG_OFF;
      bus.dp  <= DP_OFF;
      bus.an  <= AN_OFF;
    end else begin
      bus.seg <= seg_nxt_c;
      bus.dp  <= dp_nxt_c;
      bus.an  <= an_nxt_c;
    end
  end

endmodule
